// File: rtl/proc_control_pkg.sv
// Shared constants for the processor control path: opcodes (also decoded by
// the ALU), FSM state encoding and a small register-select request struct.
package proc_control_pkg;

    // 4-bit opcodes taken from IR[15:12]
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SLT = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SLR = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_MV  = 4'b0110;
    localparam logic [3:0] OP_MVI = 4'b0111;

    // FSM state encoding
    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    // Request to the one-hot register select decoders
    typedef struct packed {
        logic       en;
        logic [2:0] sel;
    } regsel_t;

    // ALU opcodes are the six codes below mv; the top half of the space is illegal
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3] == 1'b0) && (op != OP_MV) && (op != OP_MVI);
    endfunction

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-to-8 one-hot decoder with enable; drives register write enables and
// register bus-drive selects.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] y
);

    // one-hot expansion, all zeros when disabled
    always_comb begin
        y = '0;
        if (en) y[sel] = 1'b1;
    end

endmodule

// File: rtl/proc_control.sv
// Multi-cycle control FSM for a simple 8-register processor. Fetches an
// instruction word in T0, then sequences bus, register and ALU strobes over
// T1..T3. All strobes are combinational from state, IR and Run, and are
// forced low while reset is asserted.
module proc_control
    import proc_control_pkg::*;
(
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Run,
    input  logic [15:0] DIN,
    output logic        IRin,
    output logic [7:0]  Rin,
    output logic [7:0]  Rout,
    output logic        Ain,
    output logic        Gin,
    output logic        Gout,
    output logic        DINout,
    output logic [3:0]  alu_op,
    output logic        Done,
    output logic        Busy
);

    logic [1:0]  state, state_nxt;
    logic [15:0] ir;

    logic [3:0]  op;
    logic [2:0]  rx, ry;
    logic        unused_ir_low;

    assign op = ir[15:12];
    assign rx = ir[11:9];
    assign ry = ir[8:6];
    assign unused_ir_low = ^ir[5:0];

    // unmasked strobe requests from the decode logic
    regsel_t     rin_req, rout_req;
    logic        irin_c, ain_c, gin_c, gout_c, dinout_c, done_c;
    logic [3:0]  alu_c;

    // state register; reset aborts any instruction in flight
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= T0;
        else         state <= state_nxt;
    end

    // instruction register, captured on the fetch cycle
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)   ir <= 16'h0000;
        else if (IRin) ir <= DIN;
    end

    // next-state and strobe decode
    always_comb begin
        state_nxt = state;
        rin_req   = '0;
        rout_req  = '0;
        irin_c    = 1'b0;
        ain_c     = 1'b0;
        gin_c     = 1'b0;
        gout_c    = 1'b0;
        dinout_c  = 1'b0;
        done_c    = 1'b0;
        alu_c     = 4'b0000;
        case (state)
            T0: begin
                irin_c    = Run;
                state_nxt = Run ? T1 : T0;
            end
            T1: begin
                state_nxt = T0;
                if (op == OP_MV) begin
                    rout_req = '{en: 1'b1, sel: ry};
                    rin_req  = '{en: 1'b1, sel: rx};
                    done_c   = 1'b1;
                end else if (op == OP_MVI) begin
                    dinout_c = 1'b1;
                    rin_req  = '{en: 1'b1, sel: rx};
                    done_c   = 1'b1;
                end else if (is_alu_op(op)) begin
                    // first operand into A, then continue to the ALU cycle
                    rout_req  = '{en: 1'b1, sel: rx};
                    ain_c     = 1'b1;
                    state_nxt = T2;
                end else begin
                    // illegal opcode: retire without touching registers
                    done_c = 1'b1;
                end
            end
            T2: begin
                rout_req  = '{en: 1'b1, sel: ry};
                gin_c     = 1'b1;
                alu_c     = op;
                state_nxt = T3;
            end
            T3: begin
                gout_c    = 1'b1;
                rin_req   = '{en: 1'b1, sel: rx};
                done_c    = 1'b1;
                state_nxt = T0;
            end
            default: state_nxt = T0;
        endcase
    end

    dec3to8 u_dec_rin (
        .en  (rin_req.en & Resetn),
        .sel (rin_req.sel),
        .y   (Rin)
    );

    dec3to8 u_dec_rout (
        .en  (rout_req.en & Resetn),
        .sel (rout_req.sel),
        .y   (Rout)
    );

    // reset masks every strobe, including a fetch requested by Run
    assign IRin   = irin_c   & Resetn;
    assign Ain    = ain_c    & Resetn;
    assign Gin    = gin_c    & Resetn;
    assign Gout   = gout_c   & Resetn;
    assign DINout = dinout_c & Resetn;
    assign Done   = done_c   & Resetn;
    assign alu_op = alu_c & {4{Resetn}};
    assign Busy   = (state != T0) & Resetn;

endmodule

// File: tb/tb_proc_control.sv
// Bench for proc_control: directed scenarios followed by random instruction
// streams, compared cycle by cycle against a list-of-micro-steps model.
module tb_proc_control;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Run;
    logic [15:0] DIN;
    logic        IRin, Ain, Gin, Gout, DINout, Done, Busy;
    logic [7:0]  Rin, Rout;
    logic [3:0]  alu_op;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic [3:0] alu;
        logic       done;
        logic       busy;
    } ctl_t;

    // expected per-cycle strobes of the instruction currently executing
    ctl_t pending[$];

    proc_control dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .DIN    (DIN),
        .IRin   (IRin),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .alu_op (alu_op),
        .Done   (Done),
        .Busy   (Busy)
    );

    always #5 Clock = ~Clock;

    function automatic logic [7:0] onehot(input logic [2:0] r);
        logic [7:0] v;
        v = 8'd0;
        v[r] = 1'b1;
        return v;
    endfunction

    // expand an instruction into the strobes of each cycle after fetch
    task automatic schedule(input logic [15:0] instr);
        ctl_t c;
        int   op;
        op = int'(instr[15:12]);
        c = '0;
        c.busy = 1'b1;
        if (op == 6) begin
            c.rout = onehot(instr[8:6]); c.rin = onehot(instr[11:9]); c.done = 1'b1;
            pending.push_back(c);
        end else if (op == 7) begin
            c.dinout = 1'b1; c.rin = onehot(instr[11:9]); c.done = 1'b1;
            pending.push_back(c);
        end else if (op >= 8) begin
            c.done = 1'b1;
            pending.push_back(c);
        end else begin
            c.rout = onehot(instr[11:9]); c.ain = 1'b1;
            pending.push_back(c);
            c = '0; c.busy = 1'b1;
            c.rout = onehot(instr[8:6]); c.gin = 1'b1; c.alu = instr[15:12];
            pending.push_back(c);
            c = '0; c.busy = 1'b1;
            c.gout = 1'b1; c.rin = onehot(instr[11:9]); c.done = 1'b1;
            pending.push_back(c);
        end
    endtask

    // one clock: drive inputs away from the edge, check, then advance the model
    task automatic step(input string tag, input logic rn, input logic run, input logic [15:0] din);
        ctl_t exp, obs;
        @(negedge Clock);
        Resetn = rn; Run = run; DIN = din;
        #1;
        exp = '0;
        if (rn && pending.size() > 0) exp = pending[0];
        else if (rn)                  exp.irin = run;
        obs = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, alu_op, Done, Busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        checks++;
        assert ($countones({Rout, Gout, DINout}) <= 1) else begin
            errors++;
            $error("FAIL %s_bus observed=%b expected=at_most_one_driver", tag, {Rout, Gout, DINout});
        end
        if (!rn)                      pending.delete();
        else if (pending.size() > 0)  void'(pending.pop_front());
        else if (run)                 schedule(din);
    endtask

    initial begin
        Resetn = 1'b0; Run = 1'b1; DIN = 16'h0000;

        // reset with Run high: fetch masked, idle
        step("rst0", 1'b0, 1'b1, 16'h7200);
        step("rst1", 1'b0, 1'b1, 16'h7200);

        // mvi r1, #AB
        step("mvi_t0", 1'b1, 1'b1, 16'h7200);
        step("mvi_t1", 1'b1, 1'b0, 16'h00AB);
        step("idle0",  1'b1, 1'b0, 16'h0000);

        // add r0, r1
        step("add_t0", 1'b1, 1'b1, 16'h0040);
        step("add_t1", 1'b1, 1'b0, 16'h1234);
        step("add_t2", 1'b1, 1'b0, 16'h1234);
        step("add_t3", 1'b1, 1'b0, 16'h1234);

        // sll r3, r3
        step("sll_t0", 1'b1, 1'b1, 16'h36C0);
        step("sll_t1", 1'b1, 1'b0, 16'h0000);
        step("sll_t2", 1'b1, 1'b0, 16'h0000);
        step("sll_t3", 1'b1, 1'b0, 16'h0000);

        // sub with Run pulses while busy, then illegal fetch
        step("sub_t0", 1'b1, 1'b1, 16'h1280);
        step("sub_t1", 1'b1, 1'b1, 16'h6000);
        step("sub_t2", 1'b1, 1'b0, 16'h6000);
        step("sub_t3", 1'b1, 1'b1, 16'h7000);
        step("ill_t0", 1'b1, 1'b1, 16'hF000);
        step("ill_t1", 1'b1, 1'b1, 16'h0000);

        // Run held: mv back-to-back with another mv
        step("mv_t0",  1'b1, 1'b1, 16'h6A40);
        step("mv_t1",  1'b1, 1'b1, 16'h6E00);
        step("mv2_t0", 1'b1, 1'b1, 16'h6E00);
        step("mv2_t1", 1'b1, 1'b0, 16'h0000);

        // slt aborted by reset in T2
        step("slt_t0", 1'b1, 1'b1, 16'h2440);
        step("slt_t1", 1'b1, 1'b0, 16'h0000);
        step("slt_rst", 1'b0, 1'b1, 16'h0000);
        step("slt_post", 1'b1, 1'b0, 16'h0000);
        step("slt_idle", 1'b1, 1'b0, 16'h0000);

        // random streams with occasional reset
        for (int i = 0; i < 600; i++) begin
            logic rn, run;
            rn  = ($urandom_range(0, 49) != 0);
            run = ($urandom_range(0, 1) == 1);
            step("rand", rn, run, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
